gba_timers: RTL and testbench

GBA_TIMERS -- requirements
Module: gba_timers

---
 rtl/gba_timers_pkg.sv | 35 +++
 rtl/timer_channel.sv | 70 +++++++
 rtl/gba_timers.sv | 73 +++++++
 tb/tb_gba_timers.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/gba_timers_pkg.sv
// Shared definitions for the GBA timer block: MMIO register indices, control
// bit positions and the prescaler divisor table.
package gba_timers_pkg;

    localparam logic [9:0] TM0CNT_IDX = 10'h040;
    localparam logic [9:0] TM1CNT_IDX = 10'h041;
    localparam logic [9:0] TM2CNT_IDX = 10'h042;
    localparam logic [9:0] TM3CNT_IDX = 10'h043;

    localparam int unsigned CtrlCascade = 2;
    localparam int unsigned CtrlIrq     = 6;
    localparam int unsigned CtrlStart   = 7;

    typedef enum logic [1:0] {
        PrescDiv1    = 2'd0,
        PrescDiv64   = 2'd1,
        PrescDiv256  = 2'd2,
        PrescDiv1024 = 2'd3
    } presc_e;

    // Terminal prescaler count (divisor - 1) for a given select.
    function automatic logic [9:0] presc_limit(input logic [1:0] sel);
        logic [9:0] lim;
        lim = 10'd0;
        unique case (presc_e'(sel))
            PrescDiv1:    lim = 10'd0;
            PrescDiv64:   lim = 10'd63;
            PrescDiv256:  lim = 10'd255;
            PrescDiv1024: lim = 10'd1023;
            default:      lim = 10'd0;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One GBA timer: reload/counter/control registers, prescaler, cascade input,
// combinational overflow and a registered one-cycle interrupt pulse.
module timer_channel
    import gba_timers_pkg::*;
#(
    parameter int unsigned Index = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wr,
    input  logic [15:0] i_wr_reload,
    input  logic [7:0]  i_wr_ctrl,
    input  logic        i_cascade,
    output logic        o_overflow,
    output logic        o_irq,
    output logic [15:0] o_counter,
    output logic [7:0]  o_ctrl
);

    logic [15:0] r_reload;
    logic [15:0] r_counter;
    logic [7:0]  r_ctrl;
    logic [9:0]  r_presc;
    logic        r_irq;

    logic        w_start_edge;
    logic        w_cascade_mode;
    logic        w_presc_hit;
    logic        w_tick;

    assign w_start_edge   = i_wr & i_wr_ctrl[CtrlStart] & ~r_ctrl[CtrlStart];
    // Timer 0 has no predecessor, so its cascade bit is ignored.
    assign w_cascade_mode = (Index != 0) && r_ctrl[CtrlCascade];
    assign w_presc_hit    = (r_presc == presc_limit(r_ctrl[1:0]));
    assign w_tick         = r_ctrl[CtrlStart] & (w_cascade_mode ? i_cascade : w_presc_hit);
    assign o_overflow     = w_tick & (r_counter == 16'hFFFF);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_reload  <= 16'h0;
            r_counter <= 16'h0;
            r_ctrl    <= 8'h0;
            r_presc   <= 10'h0;
            r_irq     <= 1'b0;
        end else begin
            if (i_wr) begin
                r_reload <= i_wr_reload;
                r_ctrl   <= i_wr_ctrl;
            end
            if (w_start_edge) begin
                r_counter <= i_wr_reload;
                r_presc   <= 10'h0;
            end else begin
                // Overflow reloads the pre-write reload value.
                if (w_tick) begin
                    r_counter <= o_overflow ? r_reload : r_counter + 16'd1;
                end
                if (r_ctrl[CtrlStart] && !w_cascade_mode) begin
                    r_presc <= w_presc_hit ? 10'h0 : r_presc + 10'd1;
                end
            end
            r_irq <= o_overflow & r_ctrl[CtrlIrq];
        end
    end

    assign o_irq     = r_irq;
    assign o_counter = r_counter;
    assign o_ctrl    = r_ctrl;

endmodule

// File: rtl/gba_timers.sv
// Four cascadable GBA timers behind the MMIO bus, with tri-stated read data
// and per-timer overflow interrupt pulses.
module gba_timers
    import gba_timers_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] io_addr,
    input  logic        io_write,
    input  logic [31:0] bus_wdata,
    inout  wire  [31:0] io_reg_rdata,
    output logic        timer0,
    output logic        timer1,
    output logic        timer2,
    output logic        timer3
);

    logic [9:0]  w_idx;
    logic [3:0]  w_sel;
    logic [3:0]  w_ovf;
    logic [3:0]  w_irq;
    logic [3:0]  w_casc;
    logic [15:0] w_cnt [4];
    logic [7:0]  w_ctrl [4];
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_idx    = io_addr[11:2];
    assign w_sel[0] = (w_idx == TM0CNT_IDX);
    assign w_sel[1] = (w_idx == TM1CNT_IDX);
    assign w_sel[2] = (w_idx == TM2CNT_IDX);
    assign w_sel[3] = (w_idx == TM3CNT_IDX);
    assign w_casc   = {w_ovf[2:0], 1'b0};
    assign w_unused = ^{bus_wdata[31:24], io_addr[1:0]};

    for (genvar g = 0; g < 4; g++) begin : g_chan
        timer_channel #(
            .Index(g)
        ) u_chan (
            .i_clk      (clock),
            .i_rst_n    (reset),
            .i_wr       (io_write & w_sel[g]),
            .i_wr_reload(bus_wdata[15:0]),
            .i_wr_ctrl  (bus_wdata[23:16]),
            .i_cascade  (w_casc[g]),
            .o_overflow (w_ovf[g]),
            .o_irq      (w_irq[g]),
            .o_counter  (w_cnt[g]),
            .o_ctrl     (w_ctrl[g])
        );
    end

    always_comb begin
        w_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (w_sel[i]) begin
                w_rdata = {8'h0, w_ctrl[i], w_cnt[i]};
            end
        end
        // Registers may still hold stale state until the reset edge.
        if (!reset) begin
            w_rdata = 32'h0;
        end
    end

    assign io_reg_rdata = (|w_sel) ? w_rdata : {32{1'bz}};

    assign timer0 = w_irq[0];
    assign timer1 = w_irq[1];
    assign timer2 = w_irq[2];
    assign timer3 = w_irq[3];

endmodule

// File: tb/tb_gba_timers.sv
// Directed bench for gba_timers: inputs driven and outputs sampled on the
// falling clock edge, expected values worked out by hand.
module tb_gba_timers;
    import gba_timers_pkg::*;

    logic        clock;
    logic        reset;
    logic [11:0] io_addr;
    logic        io_write;
    logic [31:0] bus_wdata;
    wire  [31:0] rd_bus;
    logic        timer0, timer1, timer2, timer3;
    logic        tb_drv;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [9:0]  UnmappedIdx = 10'h055;
    localparam logic [31:0] FloatPat    = 32'hDEAD_BEEF;

    // A bench-side driver shows whether the DUT releases the bus.
    assign rd_bus = tb_drv ? FloatPat : {32{1'bz}};

    gba_timers dut (
        .clock       (clock),
        .reset       (reset),
        .io_addr     (io_addr),
        .io_write    (io_write),
        .bus_wdata   (bus_wdata),
        .io_reg_rdata(rd_bus),
        .timer0      (timer0),
        .timer1      (timer1),
        .timer2      (timer2),
        .timer3      (timer3)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic wr(input logic [9:0] idx, input logic [31:0] data);
        io_addr   = {idx, 2'b00};
        bus_wdata = data;
        io_write  = 1'b1;
        cyc();
        io_write  = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [9:0] idx, input logic [31:0] exp);
        io_addr = {idx, 2'b00};
        #1;
        check_eq(tag, rd_bus, exp);
    endtask

    task automatic float_check(input string tag);
        io_addr = {UnmappedIdx, 2'b00};
        tb_drv  = 1'b1;
        #1;
        check_eq(tag, rd_bus, FloatPat);
        tb_drv  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        io_write  = 1'b0;
        io_addr   = 12'h0;
        bus_wdata = 32'h0;
        tb_drv    = 1'b0;
        repeat (3) cyc();

        // Reset state
        rd_check("rst_read_tm0", TM0CNT_IDX, 32'h0);
        float_check("rst_unmapped_z");
        check_eq("rst_timer0", {31'b0, timer0}, 32'd0);
        reset = 1'b1;
        cyc();
        rd_check("idle_tm3", TM3CNT_IDX, 32'h0);

        // Control readback: bits [5:3] kept, [31:24] dropped
        wr(TM1CNT_IDX, 32'hFF38_0000);
        rd_check("ctrl_readback", TM1CNT_IDX, 32'h0038_0000);

        // Reload FFFE, /1, IRQ: pulse every other cycle
        do_reset();
        wr(TM0CNT_IDX, 32'h00C0_FFFE);
        rd_check("t0_start", TM0CNT_IDX, 32'h00C0_FFFE);
        check_eq("t0_irq_a", {31'b0, timer0}, 32'd0);
        cyc();
        rd_check("t0_ffff", TM0CNT_IDX, 32'h00C0_FFFF);
        check_eq("t0_irq_b", {31'b0, timer0}, 32'd0);
        cyc();
        rd_check("t0_wrap", TM0CNT_IDX, 32'h00C0_FFFE);
        check_eq("t0_irq_c", {31'b0, timer0}, 32'd1);
        cyc();
        check_eq("t0_irq_d", {31'b0, timer0}, 32'd0);
        cyc();
        check_eq("t0_irq_e", {31'b0, timer0}, 32'd1);
        // Stop: counter takes its last tick then freezes
        wr(TM0CNT_IDX, 32'h0000_0000);
        cyc();
        rd_check("t0_frozen", TM0CNT_IDX, 32'h0000_FFFF);
        check_eq("t0_irq_stop", {31'b0, timer0}, 32'd0);

        // Cascade T0 -> T1
        do_reset();
        wr(TM1CNT_IDX, 32'h00C4_FFFD);
        wr(TM0CNT_IDX, 32'h0080_FFFF);
        rd_check("t1_start", TM1CNT_IDX, 32'h00C4_FFFD);
        cyc();
        rd_check("t1_c1", TM1CNT_IDX, 32'h00C4_FFFE);
        check_eq("t0_noirq", {31'b0, timer0}, 32'd0);
        cyc();
        rd_check("t1_c2", TM1CNT_IDX, 32'h00C4_FFFF);
        check_eq("t1_irq_lo", {31'b0, timer1}, 32'd0);
        cyc();
        rd_check("t1_c3", TM1CNT_IDX, 32'h00C4_FFFD);
        check_eq("t1_irq_hi", {31'b0, timer1}, 32'd1);
        check_eq("t0_noirq2", {31'b0, timer0}, 32'd0);
        cyc();
        check_eq("t1_irq_1cyc", {31'b0, timer1}, 32'd0);

        // Full chain: T0 overflow ripples to T3 in the same cycle
        do_reset();
        wr(TM3CNT_IDX, 32'h00C4_FFFF);
        wr(TM2CNT_IDX, 32'h0084_FFFF);
        wr(TM1CNT_IDX, 32'h0084_FFFF);
        wr(TM0CNT_IDX, 32'h0080_FFFF);
        check_eq("chain_t3_pre", {31'b0, timer3}, 32'd0);
        cyc();
        check_eq("chain_t3_a", {31'b0, timer3}, 32'd1);
        cyc();
        check_eq("chain_t3_b", {31'b0, timer3}, 32'd1);
        rd_check("chain_t3_cnt", TM3CNT_IDX, 32'h00C4_FFFF);

        // /64 prescaler
        do_reset();
        wr(TM0CNT_IDX, 32'h0081_0000);
        repeat (63) cyc();
        rd_check("p64_63", TM0CNT_IDX, 32'h0081_0000);
        cyc();
        rd_check("p64_64", TM0CNT_IDX, 32'h0081_0001);
        repeat (63) cyc();
        rd_check("p64_127", TM0CNT_IDX, 32'h0081_0001);
        cyc();
        rd_check("p64_128", TM0CNT_IDX, 32'h0081_0002);

        // Running rewrite during overflow: old reload used, new one later
        do_reset();
        wr(TM2CNT_IDX, 32'h0080_FFFE);
        cyc();
        rd_check("t2_ffff", TM2CNT_IDX, 32'h0080_FFFF);
        wr(TM2CNT_IDX, 32'h0080_1234);
        rd_check("t2_old_rld", TM2CNT_IDX, 32'h0080_FFFE);
        cyc();
        rd_check("t2_ffff2", TM2CNT_IDX, 32'h0080_FFFF);
        cyc();
        rd_check("t2_new_rld", TM2CNT_IDX, 32'h0080_1234);
        cyc();
        rd_check("t2_inc", TM2CNT_IDX, 32'h0080_1235);

        // Stop written in the overflow cycle still completes the overflow
        do_reset();
        wr(TM2CNT_IDX, 32'h00C0_FFFE);
        cyc();
        wr(TM2CNT_IDX, 32'h0040_5555);
        rd_check("stop_ovf_cnt", TM2CNT_IDX, 32'h0040_FFFE);
        check_eq("stop_ovf_irq", {31'b0, timer2}, 32'd1);
        cyc();
        rd_check("stop_frozen", TM2CNT_IDX, 32'h0040_FFFE);
        check_eq("stop_irq_lo", {31'b0, timer2}, 32'd0);

        // Reset one cycle before overflow aborts the pulse
        do_reset();
        wr(TM0CNT_IDX, 32'h00C0_FFFE);
        cyc();
        reset = 1'b0;
        cyc();
        check_eq("rst_abort_irq", {31'b0, timer0}, 32'd0);
        rd_check("rst_abort_rd", TM0CNT_IDX, 32'h0);
        reset = 1'b1;
        cyc();
        check_eq("rst_abort_irq2", {31'b0, timer0}, 32'd0);
        rd_check("rst_abort_cnt", TM0CNT_IDX, 32'h0);
        float_check("unmapped_z");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
